// File: rtl/disp_mux.sv
// Four-digit seven-segment scan driver with per-frame input capture.
// Define DISP_MUX_BLANK_EN to add BLANK_CYCLES of dead time per digit.
module disp_mux #(
  parameter int REFRESH_MAX  = 50000 - 1,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dig_0,
  input  logic [7:0] dig_1,
  input  logic [7:0] dig_2,
  input  logic [7:0] dig_3,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_start
);

  typedef enum logic [1:0] {
    S_LOAD,
`ifdef DISP_MUX_BLANK_EN
    S_BLANK,
`endif
    S_SHOW
  } state_t;

  localparam logic [23:0] RMAX = 24'(REFRESH_MAX);
  localparam logic [23:0] BMAX = 24'(BLANK_CYCLES - 1);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [23:0] cnt, cnt_n;
  logic        run;
  logic        cap;
  logic [7:0]  sh_0, sh_1, sh_2, sh_3;
  logic [7:0]  sel;
  logic [3:0]  an_n;
  logic [7:0]  sseg_n;
  logic        fs_n;

`ifndef DISP_MUX_BLANK_EN
  logic unused_bmax;
  assign unused_bmax = ^BMAX;
`endif

  // run is low only in the first cycle after reset, which idles in S_LOAD
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 24'd1;
    cap     = 1'b0;
    unique case (state)
      S_LOAD: begin
        cnt_n = '0;
        if (run) begin
          cap     = (idx == 2'd0);
          state_n = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt == RMAX) begin
          cnt_n = '0;
`ifdef DISP_MUX_BLANK_EN
          state_n = S_BLANK;
`else
          state_n = S_LOAD;
          idx_n   = idx + 2'd1;
`endif
        end
      end
`ifdef DISP_MUX_BLANK_EN
      S_BLANK: begin
        if (cnt == BMAX) begin
          cnt_n   = '0;
          state_n = S_LOAD;
          idx_n   = idx + 2'd1;
        end
      end
`endif
      default: begin
        cnt_n   = '0;
        state_n = S_LOAD;
        idx_n   = 2'd0;
      end
    endcase
  end

  // Segment source bypasses the shadows on the capture edge
  always_comb begin
    sel = 8'hFF;
    unique case (idx_n)
      2'd0: sel = cap ? dig_0 : sh_0;
      2'd1: sel = cap ? dig_1 : sh_1;
      2'd2: sel = cap ? dig_2 : sh_2;
      2'd3: sel = cap ? dig_3 : sh_3;
      default: sel = 8'hFF;
    endcase
  end

  always_comb begin
    an_n   = 4'hF;
    sseg_n = 8'hFF;
    fs_n   = 1'b0;
    if (state_n == S_SHOW) begin
      an_n   = ~(4'b0001 << idx_n);
      sseg_n = sel;
    end
    if (state_n == S_LOAD && idx_n == 2'd0)
      fs_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      idx         <= 2'd0;
      cnt         <= '0;
      run         <= 1'b0;
      sh_0        <= 8'hFF;
      sh_1        <= 8'hFF;
      sh_2        <= 8'hFF;
      sh_3        <= 8'hFF;
      an          <= 4'hF;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      run         <= 1'b1;
      an          <= an_n;
      sseg        <= sseg_n;
      frame_start <= fs_n;
      if (cap) begin
        sh_0 <= dig_0;
        sh_1 <= dig_1;
        sh_2 <= dig_2;
        sh_3 <= dig_3;
      end
    end
  end

endmodule

// File: tb/tb_disp_mux.sv
// Scoreboard bench for disp_mux: per-cycle expected pins from a frame model.
// Builds with or without DISP_MUX_BLANK_EN.
module tb_disp_mux;

  localparam int R = 3;
  localparam int B = 2;
`ifdef DISP_MUX_BLANK_EN
  localparam int SLOT = 2 + R + B;
`else
  localparam int SLOT = 2 + R;
`endif
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dig_0, dig_1, dig_2, dig_3;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_start;

  disp_mux #(.REFRESH_MAX(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset),
    .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3),
    .an(an), .sseg(sseg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       fs;
    int         pos;
  } exp_t;

  typedef struct {
    logic [7:0] dig[4];
    logic [7:0] exp[4];
  } vec_t;

  exp_t       q[$];
  exp_t       e;
  vec_t       tbl[4];
  logic [7:0] nxt[4];
  logic [7:0] sh_m[4];
  int         pos;
  int         checks = 0;
  int         errors = 0;
  int         fs_cnt = 0;
  bit         mon_on = 0;
  bit         cnt_on = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp, input int p);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pos=%0d got=%h exp=%h", nm, p, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", {4'h0, an}, {4'h0, e.an}, e.pos);
      chk("sseg", sseg, e.sseg, e.pos);
      chk("frame_start", {7'h0, frame_start}, {7'h0, e.fs}, e.pos);
    end
    if (mon_on) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot got=%b exp=at_most_one_low", an);
      end
    end
    if (cnt_on && frame_start === 1'b1) fs_cnt++;
  end

  task automatic set_dig(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    dig_0 = d0; dig_1 = d1; dig_2 = d2; dig_3 = d3;
  endtask

  task automatic apply(input int i);
    set_dig(tbl[i].dig[0], tbl[i].dig[1], tbl[i].dig[2], tbl[i].dig[3]);
    nxt = tbl[i].exp;
  endtask

  task automatic tick();
    exp_t x;
    int   s, o;
    @(posedge clk);
    #1;
    if (pos % FRAME == 0) sh_m = nxt;
    s = (pos % FRAME) / SLOT;
    o = pos % SLOT;
    x.pos = pos;
    x.an = 4'hF;
    x.sseg = 8'hFF;
    x.fs = 1'b0;
    if (o == 0) begin
      x.fs = (s == 0);
    end else if (o <= R + 1) begin
      x.an = ~(4'b0001 << s);
      x.sseg = sh_m[s];
    end
    q.push_back(x);
    pos++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_blank();
    exp_t x;
    @(posedge clk);
    #1;
    x.pos = -1;
    x.an = 4'hF;
    x.sseg = 8'hFF;
    x.fs = 1'b0;
    q.push_back(x);
  endtask

  initial begin
    tbl[0].dig = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl[0].exp = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl[1].dig = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    tbl[1].exp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    tbl[2].dig = '{8'h7F, 8'hFF, 8'h00, 8'h5A};
    tbl[2].exp = '{8'h7F, 8'hFF, 8'h00, 8'h5A};
    tbl[3].dig = '{8'h92, 8'h82, 8'hF8, 8'h80};
    tbl[3].exp = '{8'h92, 8'h82, 8'hF8, 8'h80};

    // reset held three cycles
    apply(0);
    reset = 1'b1;
    repeat (3) push_blank();
    reset = 1'b0;
    pos = 0;
    mon_on = 1;

    // one frame per table vector
    for (int i = 0; i < 4; i++) begin
      if (i > 0) apply(i);
      run(FRAME);
    end

    // dig_2 changes mid-frame while idx=1
    apply(0);
    run(FRAME);
    run(SLOT + 1);
    dig_2 = 8'h92;
    nxt[2] = 8'h92;
    run(FRAME - SLOT - 1);
    run(FRAME);

    // reset pulse during digit 2 on-time
    run(2 * SLOT + 3);
    apply(2);
    reset = 1'b1;
    push_blank();
    reset = 1'b0;
    pos = 0;
    run(2 * FRAME);

    // long run with fresh patterns each frame
    fs_cnt = 0;
    cnt_on = 1;
    for (int f = 0; f < 1000; f++) begin
      set_dig(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      nxt = '{dig_0, dig_1, dig_2, dig_3};
      run(FRAME);
    end
    @(negedge clk);
    cnt_on = 0;
    checks++;
    if (fs_cnt < 999 || fs_cnt > 1001) begin
      errors++;
      $display("FAIL fs_count got=%0d exp=1000", fs_cnt);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
